// File: rtl/noc_slave_port.sv
`default_nettype none
// ============================================================================
// Module   : noc_slave_port
// Purpose  : Splits header+payload packets popped from the arbiter FIFO into
//            single-byte slave writes. Optional ack timeout with payload
//            drain is enabled by defining NOC_SLAVE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module noc_slave_port #(
  parameter int DSIZE   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             fifo_rempty,
  input  logic [DSIZE-1:0] fifo_rdata,
  output logic             fifo_rden,
  output logic             slave_req,
  output logic [3:0]       slave_addr,
  output logic [DSIZE-1:0] slave_data,
  input  logic             slave_ack,
  output logic             pkt_done,
  output logic             busy,
  output logic             err_timeout
);

  if (DSIZE < 8) begin : g_dsize_check
    $error("noc_slave_port: DSIZE must be at least 8 to hold a header byte");
  end

  if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_timeout_check
    $error("noc_slave_port: TIMEOUT must fit the 4-bit ack-wait counter (1..15)");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    FETCH = 3'd2,
    LOAD  = 3'd3,
    SEND  = 3'd4,
    DRAIN = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_arm;
  logic [3:0]       r_remaining;
  logic [3:0]       w_remaining_nxt;
  logic [3:0]       w_remaining_dec;
  logic             r_slave_req;
  logic             w_slave_req_nxt;
  logic [3:0]       r_slave_addr;
  logic [3:0]       w_slave_addr_nxt;
  logic [DSIZE-1:0] r_slave_data;
  logic [DSIZE-1:0] w_slave_data_nxt;
  logic             r_pkt_done;
  logic             w_pkt_done_nxt;
  logic             w_fifo_rden;

`ifdef NOC_SLAVE_TIMEOUT_EN
  localparam logic [3:0] c_timeout = 4'(TIMEOUT);
  logic [3:0] r_to_cnt;
  logic [3:0] w_to_cnt_nxt;
  logic       w_to_hit;
  logic       r_err_timeout;
  logic       w_err_timeout_nxt;

  // Fires on the SEND cycle whose missing ack would bring the count to TIMEOUT.
  assign w_to_hit = ((r_to_cnt + 4'd1) == c_timeout);
`endif

  // Saturating decrement keeps the byte count from wrapping below zero.
  assign w_remaining_dec = (r_remaining != 4'd0) ? (r_remaining - 4'd1) : 4'd0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_arm        <= 1'b0;
      r_remaining  <= 4'd0;
      r_slave_req  <= 1'b0;
      r_slave_addr <= 4'd0;
      r_slave_data <= '0;
      r_pkt_done   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_arm        <= 1'b1;
      r_remaining  <= w_remaining_nxt;
      r_slave_req  <= w_slave_req_nxt;
      r_slave_addr <= w_slave_addr_nxt;
      r_slave_data <= w_slave_data_nxt;
      r_pkt_done   <= w_pkt_done_nxt;
    end
  end

`ifdef NOC_SLAVE_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_to_cnt      <= 4'd0;
      r_err_timeout <= 1'b0;
    end else begin
      r_to_cnt      <= w_to_cnt_nxt;
      r_err_timeout <= w_err_timeout_nxt;
    end
  end
`endif

  always_comb begin
    w_state_nxt       = r_state;
    w_remaining_nxt   = r_remaining;
    w_slave_req_nxt   = r_slave_req;
    w_slave_addr_nxt  = r_slave_addr;
    w_slave_data_nxt  = r_slave_data;
    w_pkt_done_nxt    = 1'b0;
    w_fifo_rden       = 1'b0;
`ifdef NOC_SLAVE_TIMEOUT_EN
    w_to_cnt_nxt      = r_to_cnt;
    w_err_timeout_nxt = 1'b0;
`endif

    case (r_state)
      IDLE: begin
        // r_arm holds off the first pop until one edge after reset release.
        w_fifo_rden = r_arm & ~fifo_rempty;
        if (w_fifo_rden) begin
          w_state_nxt = HDR;
        end
      end

      HDR: begin
        w_slave_addr_nxt = fifo_rdata[3:0];
        w_remaining_nxt  = fifo_rdata[7:4];
        if (fifo_rdata[7:4] == 4'd0) begin
          w_pkt_done_nxt = 1'b1;
          w_state_nxt    = IDLE;
        end else begin
          w_state_nxt    = FETCH;
        end
      end

      FETCH: begin
        w_fifo_rden = ~fifo_rempty;
        if (w_fifo_rden) begin
          w_state_nxt = LOAD;
        end
      end

      LOAD: begin
        w_slave_data_nxt = fifo_rdata;
        w_slave_req_nxt  = 1'b1;
        w_state_nxt      = SEND;
`ifdef NOC_SLAVE_TIMEOUT_EN
        w_to_cnt_nxt     = 4'd0;
`endif
      end

      SEND: begin
        // Ack takes priority over a timeout landing on the same cycle.
        if (slave_ack) begin
          w_slave_req_nxt = 1'b0;
          w_remaining_nxt = w_remaining_dec;
          if (w_remaining_dec == 4'd0) begin
            w_pkt_done_nxt = 1'b1;
            w_state_nxt    = IDLE;
          end else begin
            w_state_nxt    = FETCH;
          end
        end
`ifdef NOC_SLAVE_TIMEOUT_EN
        else if (w_to_hit) begin
          // The unacked byte is abandoned; only unpopped payload is drained.
          w_slave_req_nxt   = 1'b0;
          w_err_timeout_nxt = 1'b1;
          w_remaining_nxt   = w_remaining_dec;
          w_state_nxt       = DRAIN;
        end else begin
          w_to_cnt_nxt      = r_to_cnt + 4'd1;
        end
`endif
      end

`ifdef NOC_SLAVE_TIMEOUT_EN
      DRAIN: begin
        if (r_remaining == 4'd0) begin
          w_pkt_done_nxt = 1'b1;
          w_state_nxt    = IDLE;
        end else begin
          w_fifo_rden = ~fifo_rempty;
          if (w_fifo_rden) begin
            w_remaining_nxt = w_remaining_dec;
            if (w_remaining_dec == 4'd0) begin
              w_pkt_done_nxt = 1'b1;
              w_state_nxt    = IDLE;
            end
          end
        end
      end
`endif

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign fifo_rden  = w_fifo_rden;
  assign slave_req  = r_slave_req;
  assign slave_addr = r_slave_addr;
  assign slave_data = r_slave_data;
  assign pkt_done   = r_pkt_done;
  assign busy       = (r_state != IDLE);

`ifdef NOC_SLAVE_TIMEOUT_EN
  assign err_timeout = r_err_timeout;
`else
  assign err_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_slave_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_slave_port
// Purpose  : Directed and randomized packet traffic for noc_slave_port,
//            checked against a packet-level expectation queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_slave_port;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       fifo_rempty = 1'b1;
  logic [7:0] fifo_rdata = 8'h00;
  logic       fifo_rden;
  logic       slave_req;
  logic [3:0] slave_addr;
  logic [7:0] slave_data;
  logic       slave_ack = 1'b0;
  logic       pkt_done;
  logic       busy;
  logic       err_timeout;

  noc_slave_port #(.DSIZE(8), .TIMEOUT(15)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .fifo_rempty (fifo_rempty),
    .fifo_rdata  (fifo_rdata),
    .fifo_rden   (fifo_rden),
    .slave_req   (slave_req),
    .slave_addr  (slave_addr),
    .slave_data  (slave_data),
    .slave_ack   (slave_ack),
    .pkt_done    (pkt_done),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  logic r_pop = 1'b0;
  always @(posedge clk) r_pop <= rstn && fifo_rden;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pops = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          xfer_cnt = 0;
  int          first_pop_cyc = -1;
  int          done_cyc = 0;
  int          err_cyc = 0;
  int          xfer_cyc = 0;
  int          ack_mode = 0;
  int          feed = 0;
  int          rises[$];
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [11:0] prev_ad = '0;
  logic [7:0]  fq[$];
  logic [7:0]  src[$];
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: FIFO model, ack driver, then protocol monitor.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (r_pop && fq.size() > 0) begin
      fifo_rdata = fq.pop_front();
      pops++;
    end
    if (feed == 0) begin
      while (src.size() > 0) fq.push_back(src.pop_front());
    end else if (src.size() > 0 && $urandom_range(0, 1) == 1) begin
      fq.push_back(src.pop_front());
    end
    fifo_rempty = (fq.size() == 0);
    case (ack_mode)
      0:       slave_ack = 1'b0;
      1:       slave_ack = 1'b1;
      default: slave_ack = ($urandom_range(0, 2) != 0);
    endcase
    #1;
    if (fifo_rden) begin
      check("pop_nonempty", fifo_rempty, 0);
      check("no_pop_in_send", slave_req, 0);
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
    end
    if (prev_req && !prev_ack) begin
      check("req_hold", slave_req, 1);
      check("addr_data_hold", {slave_addr, slave_data}, prev_ad);
    end
    if (slave_req) begin
      check("busy_in_send", busy, 1);
      if (!prev_req) rises.push_back(cyc);
    end
    if (slave_req && slave_ack) begin
      xfer_cnt++;
      xfer_cyc = cyc;
      check("xfer_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("xfer_addr_data", {slave_addr, slave_data}, exp_q.pop_front());
    end
    if (pkt_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err_timeout) begin
      err_cnt++;
      err_cyc = cyc;
    end
    prev_req = slave_req;
    prev_ack = slave_ack;
    prev_ad  = {slave_addr, slave_data};
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done_in_budget"}, (done_cnt >= target), 1);
    tick();
  endtask

  task automatic wait_req(input int budget, input string tag);
    int n;
    n = 0;
    while (!slave_req && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_req_in_budget"}, slave_req, 1);
  endtask

  int          base_done;
  int          base_err;
  int          base_xfer;
  int          total_bytes;
  logic [3:0]  last_addr;
  logic [3:0]  r_n;
  logic [3:0]  r_a;
  logic [7:0]  r_d;

  initial begin
    // Reset with a loaded FIFO: nothing may pop while rstn is low.
    src.push_back(8'h23); src.push_back(8'hAA); src.push_back(8'hBB);
    repeat (3) tick();
    check("reset_outputs", {slave_req, slave_addr, slave_data, pkt_done, err_timeout, busy}, 0);
    check("reset_no_pop", fifo_rden, 0);
    rstn = 1'b1;
    #1;
    check("release_no_early_pop", fifo_rden, 0);

    // Basic two-byte packet, immediate ack.
    exp_q.push_back({4'h3, 8'hAA});
    exp_q.push_back({4'h3, 8'hBB});
    ack_mode = 1;
    wait_done(1, 60, "basic");
    check("basic_rises", (rises.size() == 2), 1);
    if (rises.size() == 2) begin
      check("basic_latency", rises[0] - first_pop_cyc, 4);
      check("basic_throughput", rises[1] - rises[0], 3);
    end
    check("basic_done_after_ack", done_cyc - xfer_cyc, 1);
    check("basic_pops", pops, 3);
    check("basic_addr_hold", slave_addr, 4'h3);
    check("basic_exp_empty", exp_q.size(), 0);

    // Zero-length packet.
    pops = 0; first_pop_cyc = -1; rises.delete();
    src.push_back(8'h05);
    wait_done(2, 20, "n0");
    check("n0_done_latency", done_cyc - first_pop_cyc, 2);
    check("n0_no_req", rises.size(), 0);
    check("n0_addr", slave_addr, 4'h5);
    check("n0_pops", pops, 1);

    // FIFO runs dry between header and payload.
    pops = 0;
    src.push_back(8'h17);
    repeat (7) tick();
    check("starve_busy", busy, 1);
    check("starve_no_req", slave_req, 0);
    check("starve_pops", pops, 1);
    exp_q.push_back({4'h7, 8'h5C});
    src.push_back(8'h5C);
    wait_done(3, 30, "starve");
    check("starve_pops_total", pops, 2);
    check("starve_addr", slave_addr, 4'h7);

    // Reset asserted mid-packet.
    base_done = done_cnt;
    ack_mode = 0;
    src.push_back(8'h21); src.push_back(8'h11);
    wait_req(30, "rst");
    rstn = 1'b0;
    prev_req = 1'b0;
    #1;
    check("rst_mid_outputs", {slave_req, slave_addr, slave_data, pkt_done, err_timeout, busy, fifo_rden}, 0);
    repeat (2) tick();
    rstn = 1'b1;
    check("rst_no_done", done_cnt, base_done);
    exp_q.push_back({4'h4, 8'h99});
    src.push_back(8'h14); src.push_back(8'h99);
    ack_mode = 1;
    wait_done(base_done + 1, 40, "rst_after");
    check("rst_after_addr", slave_addr, 4'h4);
    check("rst_after_exp_empty", exp_q.size(), 0);

`ifdef NOC_SLAVE_TIMEOUT_EN
    // Ack never comes: timeout, drain second byte, complete.
    base_done = done_cnt; base_err = err_cnt; pops = 0; rises.delete();
    ack_mode = 0;
    src.push_back(8'h22); src.push_back(8'hC1); src.push_back(8'hC2);
    wait_done(base_done + 1, 80, "to");
    check("to_err_count", err_cnt - base_err, 1);
    check("to_rises", rises.size(), 1);
    if (rises.size() == 1) check("to_err_latency", err_cyc - rises[0], 15);
    check("to_pops", pops, 3);
    check("to_idle", busy, 0);

    // Ack on the last permitted cycle wins over the timeout.
    base_done = done_cnt; base_err = err_cnt;
    exp_q.push_back({4'h6, 8'hD1});
    src.push_back(8'h16); src.push_back(8'hD1);
    wait_req(30, "to_edge");
    repeat (13) tick();
    ack_mode = 1;
    wait_done(base_done + 1, 20, "to_edge");
    check("to_edge_no_err", err_cnt, base_err);
    check("to_edge_exp_empty", exp_q.size(), 0);
`else
    // Ack never comes: SEND holds indefinitely, no error.
    base_done = done_cnt; base_err = err_cnt; base_xfer = xfer_cnt;
    ack_mode = 0;
    exp_q.push_back({4'h2, 8'hC1});
    exp_q.push_back({4'h2, 8'hC2});
    exp_q.push_back({4'h2, 8'hC3});
    src.push_back(8'h32); src.push_back(8'hC1); src.push_back(8'hC2);
    wait_req(30, "hold");
    repeat (40) tick();
    check("hold_req_high", slave_req, 1);
    check("hold_addr_data", {slave_addr, slave_data}, {4'h2, 8'hC1});
    check("hold_no_err", err_cnt, base_err);
    check("hold_no_xfer", xfer_cnt, base_xfer);
    src.push_back(8'hC3);
    ack_mode = 1;
    wait_done(base_done + 1, 60, "hold");
    check("hold_exp_empty", exp_q.size(), 0);
`endif

    // Randomized packets, random FIFO gaps and random ack delays.
    base_done = done_cnt; base_err = err_cnt; pops = 0; total_bytes = 0;
    last_addr = slave_addr;
    for (int p = 0; p < 25; p++) begin
      r_n = 4'($urandom_range(0, 5));
      r_a = 4'($urandom_range(0, 15));
      src.push_back({r_n, r_a});
      total_bytes++;
      for (int i = 0; i < int'(r_n); i++) begin
        r_d = 8'($urandom_range(0, 255));
        src.push_back(r_d);
        exp_q.push_back({r_a, r_d});
        total_bytes++;
      end
      last_addr = r_a;
    end
    feed = 1;
    ack_mode = 2;
    wait_done(base_done + 25, 4000, "rand");
    check("rand_exp_empty", exp_q.size(), 0);
    check("rand_pops", pops, total_bytes);
    check("rand_addr_hold", slave_addr, last_addr);
    check("rand_idle", busy, 0);
    check("rand_no_err", err_cnt, base_err);
    check("rand_done_exact", done_cnt, base_done + 25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
